// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad-multiplier calculator sequencer.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_ENT_A = 3'd0,
    ST_ENT_B = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SHOW  = 3'd4
  } calc_state_t;

  localparam logic [3:0]  KEY_MAX_DIGIT = 4'd9;
  localparam logic [3:0]  KEY_ENTER     = 4'hA;
  localparam logic [3:0]  KEY_CLEAR     = 4'hB;

  localparam logic [1:0]  SEL_A   = 2'd0;
  localparam logic [1:0]  SEL_B   = 2'd1;
  localparam logic [1:0]  SEL_RES = 2'd2;
  localparam logic [1:0]  SEL_ERR = 2'd3;

  localparam logic [15:0] DISP_ERR = 16'hFFFF;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/dec_acc8.sv
// 8-bit decimal operand accumulator with a digit counter; out-of-range or
// excess digits are dropped without changing the value.
module dec_acc8
  import calc_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load_digit,
  input  logic [3:0] digit,
  output logic [7:0] acc,
  output logic       accepted
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

  logic [7:0]    acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   next_val;

  assign next_val = 12'(acc_q) * 12'd10 + 12'(digit);
  assign accepted = load_digit &&
                    (clear || ((cnt_q < CW'(MAX_DIGITS)) && (next_val <= 12'd255)));

  // clear together with load_digit restarts the operand at that digit
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      if (load_digit) begin
        acc_d = 8'(digit);
        cnt_d = CW'(1);
      end
    end else if (accepted) begin
      acc_d = next_val[7:0];
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: operand entry, multiplier launch with timeout, and
// selection of the value shown on the BCD / 7-segment path.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned MAX_DIGITS  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        mul_done,
  input  logic [15:0] mul_result,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  output logic        mul_start,
  output logic [15:0] disp_value,
  output logic [1:0]  disp_sel,
  output logic        busy,
  output logic        err
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  calc_state_t   state_q, state_d;
  logic [15:0]   result_q, result_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic key_digit, key_enter, key_clear, restart;
  logic a_load, a_clear, a_ok, b_load, b_clear, b_ok;

  assign key_digit = key_valid && is_digit(key_code);
  assign key_enter = key_valid && (key_code == KEY_ENTER);
  assign key_clear = key_valid && (key_code == KEY_CLEAR);
  assign restart   = key_digit && (state_q == ST_SHOW);

  assign a_clear = key_clear || restart;
  assign a_load  = key_digit && ((state_q == ST_ENT_A) || (state_q == ST_SHOW));
  assign b_clear = key_clear || restart;
  assign b_load  = key_digit && (state_q == ST_ENT_B);

  dec_acc8 #(.MAX_DIGITS(MAX_DIGITS)) u_acc_a (
    .clk        (clk),
    .rst        (rst),
    .clear      (a_clear),
    .load_digit (a_load),
    .digit      (key_code),
    .acc        (op_a),
    .accepted   (a_ok)
  );

  dec_acc8 #(.MAX_DIGITS(MAX_DIGITS)) u_acc_b (
    .clk        (clk),
    .rst        (rst),
    .clear      (b_clear),
    .load_digit (b_load),
    .digit      (key_code),
    .acc        (op_b),
    .accepted   (b_ok)
  );

  // CLEAR overrides everything, including a mul_done arriving in WAIT
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    if (key_clear) begin
      state_d  = ST_ENT_A;
      result_d = '0;
      err_d    = 1'b0;
      tmo_d    = '0;
    end else begin
      case (state_q)
        ST_ENT_A: if (key_enter) state_d = ST_ENT_B;
        ST_ENT_B: if (key_enter) state_d = ST_START;
        ST_START: begin
          state_d = ST_WAIT;
          tmo_d   = '0;
        end
        ST_WAIT: begin
          if (mul_done) begin
            result_d = mul_result;
            state_d  = ST_SHOW;
          end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            err_d   = 1'b1;
            state_d = ST_SHOW;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        ST_SHOW: if (key_digit) begin
          state_d = ST_ENT_A;
          err_d   = 1'b0;
        end
        default: state_d = ST_ENT_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ENT_A;
      result_q <= '0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign mul_start = (state_q == ST_START);
  assign busy      = (state_q == ST_START) || (state_q == ST_WAIT);
  assign err       = err_q;

  always_comb begin
    disp_value = {8'h00, op_a};
    disp_sel   = SEL_A;
    case (state_q)
      ST_ENT_B, ST_START, ST_WAIT: begin
        disp_value = {8'h00, op_b};
        disp_sel   = SEL_B;
      end
      ST_SHOW: begin
        disp_value = err_q ? DISP_ERR : result_q;
        disp_sel   = err_q ? SEL_ERR  : SEL_RES;
      end
      default: ;
    endcase
  end

  a_accept_only_when_loading: assert property (@(posedge clk) disable iff (rst) a_ok |-> a_load);
  b_accept_only_when_loading: assert property (@(posedge clk) disable iff (rst) b_ok |-> b_load);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: directed vector table, hand-written corner
// sequences and random keys, all checked against a behavioural model.
module tb_calc_seq_ctrl;

  localparam int unsigned TO   = 1024;
  localparam int unsigned MAXD = 3;

  localparam int P_ENTA  = 0;
  localparam int P_ENTB  = 1;
  localparam int P_START = 2;
  localparam int P_WAIT  = 3;
  localparam int P_SHOW  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        mul_done = 1'b0;
  logic [15:0] mul_result = 16'd0;
  logic [7:0]  op_a, op_b;
  logic        mul_start, busy, err;
  logic [15:0] disp_value;
  logic [1:0]  disp_sel;

  calc_seq_ctrl #(.TIMEOUT_CYC(TO), .MAX_DIGITS(MAXD)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .op_a       (op_a),
    .op_b       (op_b),
    .mul_start  (mul_start),
    .disp_value (disp_value),
    .disp_sel   (disp_sel),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // behavioural model state
  int m_phase, m_a, m_b, m_na, m_nb, m_res, m_wait, m_err;

  typedef struct {
    bit          kv;
    logic [3:0]  kc;
    bit          md;
    logic [15:0] mr;
    int a, b, sel, disp, st, bsy, er;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_ENTA;
    m_a = 0; m_b = 0; m_na = 0; m_nb = 0;
    m_res = 0; m_wait = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit kv, input logic [3:0] kc, input bit md, input logic [15:0] mr);
    int d, t;
    bit dig, ent, clr;
    d   = int'(kc);
    dig = kv && (d <= 9);
    ent = kv && (d == 10);
    clr = kv && (d == 11);
    if (clr) begin
      model_reset();
    end else begin
      case (m_phase)
        P_ENTA: begin
          if (dig) begin
            t = m_a * 10 + d;
            if (m_na < int'(MAXD) && t <= 255) begin m_a = t; m_na++; end
          end else if (ent) m_phase = P_ENTB;
        end
        P_ENTB: begin
          if (dig) begin
            t = m_b * 10 + d;
            if (m_nb < int'(MAXD) && t <= 255) begin m_b = t; m_nb++; end
          end else if (ent) m_phase = P_START;
        end
        P_START: begin m_phase = P_WAIT; m_wait = 0; end
        P_WAIT: begin
          m_wait++;
          if (md) begin m_res = int'(mr); m_phase = P_SHOW; end
          else if (m_wait == int'(TO)) begin m_err = 1; m_phase = P_SHOW; end
        end
        default: begin
          if (dig) begin
            m_a = d; m_na = 1; m_b = 0; m_nb = 0; m_err = 0; m_phase = P_ENTA;
          end
        end
      endcase
    end
  endtask

  task automatic check_model();
    int ed, es;
    case (m_phase)
      P_ENTA:                  begin ed = m_a; es = 0; end
      P_ENTB, P_START, P_WAIT: begin ed = m_b; es = 1; end
      default:                 begin ed = m_err ? 65535 : m_res; es = m_err ? 3 : 2; end
    endcase
    chk("op_a",       int'(op_a),       m_a);
    chk("op_b",       int'(op_b),       m_b);
    chk("mul_start",  int'(mul_start),  int'(m_phase == P_START));
    chk("busy",       int'(busy),       int'(m_phase == P_START || m_phase == P_WAIT));
    chk("err",        int'(err),        m_err);
    chk("disp_value", int'(disp_value), ed);
    chk("disp_sel",   int'(disp_sel),   es);
  endtask

  task automatic step(input bit kv, input logic [3:0] kc, input bit md, input logic [15:0] mr);
    key_valid  = kv;
    key_code   = kc;
    mul_done   = md;
    mul_result = mr;
    @(posedge clk);
    model_edge(kv, kc, md, mr);
    cyc++;
    #1;
    check_model();
    key_valid  = 1'b0;
    key_code   = 4'd0;
    mul_done   = 1'b0;
    mul_result = 16'd0;
  endtask

  task automatic add(input bit kv, input int kc, input bit md, input int mr,
                     input int a, input int b, input int sel, input int disp,
                     input int st, input int bsy, input int er);
    vec_t v;
    v.kv = kv; v.kc = 4'(kc); v.md = md; v.mr = 16'(mr);
    v.a = a; v.b = b; v.sel = sel; v.disp = disp; v.st = st; v.bsy = bsy; v.er = er;
    tbl.push_back(v);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".op_a"},       int'(op_a),       0);
    chk({tag, ".op_b"},       int'(op_b),       0);
    chk({tag, ".mul_start"},  int'(mul_start),  0);
    chk({tag, ".busy"},       int'(busy),       0);
    chk({tag, ".err"},        int'(err),        0);
    chk({tag, ".disp_value"}, int'(disp_value), 0);
    chk({tag, ".disp_sel"},   int'(disp_sel),   0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int r;
    bit kv, md;
    logic [3:0] kc;

    // async reset values
    #2 rst = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_reset();

    // kv kc md mr | a b sel disp start busy err
    add(1, 1,  0, 0,   1,  0, 0, 1,   0, 0, 0);
    add(1, 2,  0, 0,   12, 0, 0, 12,  0, 0, 0);
    add(1, 10, 0, 0,   12, 0, 1, 0,   0, 0, 0);
    add(1, 3,  0, 0,   12, 3, 1, 3,   0, 0, 0);
    add(1, 4,  0, 0,   12, 34, 1, 34, 0, 0, 0);
    add(1, 10, 0, 0,   12, 34, 1, 34, 1, 1, 0);
    add(0, 0,  0, 0,   12, 34, 1, 34, 0, 1, 0);
    add(0, 0,  0, 0,   12, 34, 1, 34, 0, 1, 0);
    add(0, 0,  0, 0,   12, 34, 1, 34, 0, 1, 0);
    add(0, 0,  1, 408, 12, 34, 2, 408, 0, 0, 0);
    add(1, 10, 0, 0,   12, 34, 2, 408, 0, 0, 0);
    add(1, 2,  0, 0,   2,  0, 0, 2,   0, 0, 0);
    add(1, 12, 0, 0,   2,  0, 0, 2,   0, 0, 0);
    add(1, 13, 0, 0,   2,  0, 0, 2,   0, 0, 0);
    add(1, 14, 0, 0,   2,  0, 0, 2,   0, 0, 0);
    add(1, 15, 0, 0,   2,  0, 0, 2,   0, 0, 0);
    add(1, 5,  0, 0,   25, 0, 0, 25,  0, 0, 0);
    add(1, 6,  0, 0,   25, 0, 0, 25,  0, 0, 0);
    add(1, 10, 0, 0,   25, 0, 1, 0,   0, 0, 0);
    add(1, 0,  0, 0,   25, 0, 1, 0,   0, 0, 0);
    add(1, 0,  0, 0,   25, 0, 1, 0,   0, 0, 0);
    add(1, 7,  0, 0,   25, 7, 1, 7,   0, 0, 0);
    add(1, 9,  0, 0,   25, 7, 1, 7,   0, 0, 0);
    add(1, 10, 0, 0,   25, 7, 1, 7,   1, 1, 0);
    add(1, 3,  0, 0,   25, 7, 1, 7,   0, 1, 0);
    add(1, 10, 0, 0,   25, 7, 1, 7,   0, 1, 0);
    add(1, 11, 1, 99,  0,  0, 0, 0,   0, 0, 0);
    add(0, 0,  1, 555, 0,  0, 0, 0,   0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].kv, tbl[i].kc, tbl[i].md, tbl[i].mr);
      chk($sformatf("vec%0d.op_a", i),       int'(op_a),       tbl[i].a);
      chk($sformatf("vec%0d.op_b", i),       int'(op_b),       tbl[i].b);
      chk($sformatf("vec%0d.disp_sel", i),   int'(disp_sel),   tbl[i].sel);
      chk($sformatf("vec%0d.disp_value", i), int'(disp_value), tbl[i].disp);
      chk($sformatf("vec%0d.mul_start", i),  int'(mul_start),  tbl[i].st);
      chk($sformatf("vec%0d.busy", i),       int'(busy),       tbl[i].bsy);
      chk($sformatf("vec%0d.err", i),        int'(err),        tbl[i].er);
    end

    // timeout: WAIT residency must be exactly TO cycles
    step(1, 4'd3, 0, 16'd0);
    step(1, 4'hA, 0, 16'd0);
    step(1, 4'd4, 0, 16'd0);
    step(1, 4'hA, 0, 16'd0);
    waited = 0;
    for (int i = 0; i < int'(TO) + 8 && disp_sel != 2'd3; i++) begin
      step(0, 4'd0, 0, 16'd0);
      if (busy && !mul_start) waited++;
    end
    chk("timeout_wait_cycles", waited, int'(TO));
    chk("timeout_err",  int'(err), 1);
    chk("timeout_disp", int'(disp_value), 65535);
    chk("timeout_sel",  int'(disp_sel), 3);
    step(1, 4'd5, 0, 16'd0);
    chk("restart_a",   int'(op_a), 5);
    chk("restart_b",   int'(op_b), 0);
    chk("restart_err", int'(err), 0);
    chk("restart_sel", int'(disp_sel), 0);

    // mul_done on the very cycle the timeout would expire
    step(1, 4'hA, 0, 16'd0);
    step(1, 4'd8, 0, 16'd0);
    step(1, 4'hA, 0, 16'd0);
    step(0, 4'd0, 0, 16'd0);
    for (int i = 0; i < int'(TO) - 1; i++) step(0, 4'd0, 0, 16'd0);
    step(0, 4'd0, 1, 16'd1234);
    chk("race_err",  int'(err), 0);
    chk("race_disp", int'(disp_value), 1234);
    chk("race_sel",  int'(disp_sel), 2);

    // asynchronous reset while in START
    step(1, 4'hB, 0, 16'd0);
    step(1, 4'd2, 0, 16'd0);
    step(1, 4'hA, 0, 16'd0);
    step(1, 4'd3, 0, 16'd0);
    step(1, 4'hA, 0, 16'd0);
    chk("pre_rst_start", int'(mul_start), 1);
    #3 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1 chk_reset_outputs("rst_held");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 4'd0, 1, 16'd77);

    // random keys and multiplier responses
    for (int i = 0; i < 3000; i++) begin
      kv = ($urandom_range(0, 99) < 40);
      r  = int'($urandom_range(0, 99));
      if (r < 60)      kc = 4'($urandom_range(0, 9));
      else if (r < 82) kc = 4'hA;
      else if (r < 85) kc = 4'hB;
      else             kc = 4'($urandom_range(12, 15));
      md = ($urandom_range(0, 9) == 0);
      step(kv, kc, md, 16'($urandom_range(0, 65535)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
# calc_seq_ctrl

Sequencing controller for the keypad-multiplier calculator. It consumes decoded key events and accumulates two unsigned decimal operands. It then launches the multiplier with a one-cycle start pulse and waits for its done flag, with a timeout. It drives the 16-bit value and source-select that feed the BCD / 7-segment path. It replaces the loose `listo_1`/`listo` flag coupling with an explicit state machine.

## Interface
- `TIMEOUT_CYC`, 1024: max cycles spent in WAIT before error.
- `MAX_DIGITS`, 3: max decimal digits per operand.
- `clk`  in  1  clock; all registers on rising edge.
- `rst`  in  1  reset `rst`, asynchronous, active-high.
- `key_valid`  in  1  one-cycle pulse; `key_code` valid this cycle.
- `key_code`  in  4  0–9 digit, 4'hA ENTER, 4'hB CLEAR, others ignored.
- `mul_done`  in  1  multiplier result valid (pulse or level).
- `mul_result`  in  16  unsigned product; sampled only when `mul_done` is high in WAIT.
- `op_a`  out  8  operand A register to the multiplier.
- `op_b`  out  8  operand B register to the multiplier.
- `mul_start`  out  1  one-cycle launch pulse.
- `disp_value`  out  16  value for the BCD converter.
- `disp_sel`  out  2  0 = A, 1 = B, 2 = result, 3 = error.
- `busy`  out  1  high in START and WAIT.
- `err`  out  1  sticky timeout flag; cleared by CLEAR, a new digit in SHOW, or reset.

## Operation
- States:
  - ENT_A: digits accumulate into A; ENTER goes to ENT_B.
  - ENT_B: digits accumulate into B; ENTER goes to START.
  - START: one cycle, `mul_start` = 1, then WAIT.
  - WAIT: `mul_done` captures `mul_result` into `result` and goes to SHOW. Timeout goes to SHOW with `err` = 1.
  - SHOW: result is displayed. A digit goes to ENT_A with A = that digit, B = 0, `err` = 0. ENTER is ignored.
- Digit accumulate: `new = acc*10 + d`, computed at ≥12 bits. The digit is accepted only if fewer than `MAX_DIGITS` digits have been entered and `new` ≤ 255. Otherwise it is silently dropped and `acc` is unchanged.
- Leading zeros count as digits.
- CLEAR in any state goes to ENT_A with A = B = `result` = 0, digit counters = 0, `err` = 0, timeout counter = 0. This aborts an in-flight multiply.
- In START and WAIT, all keys except CLEAR are ignored. `mul_done` outside WAIT is ignored.
- Simultaneous events:
  - CLEAR with `mul_done` in WAIT: CLEAR wins and the result is discarded.
  - `mul_done` in the same cycle the timeout expires: `mul_done` wins and `err` stays 0.
- `disp_value` / `disp_sel` are combinational from registered state:
  - ENT_A: A zero-extended, sel 0.
  - ENT_B, START, WAIT: B zero-extended, sel 1.
  - SHOW without err: `result`, sel 2.
  - SHOW with err: 16'hFFFF, sel 3.
- Arithmetic is unsigned only; there is no sign handling.

## Timing
- Reset values: state ENT_A; `op_a` = `op_b` = 0; `result` = 0; `mul_start` = 0; `busy` = 0; `err` = 0; `disp_value` = 0; `disp_sel` = 0.
- Key effect: a key sampled at edge N updates operand and state registers at N; outputs reflect it in the cycle after edge N.
- ENTER in ENT_B at edge N: START is entered at N and `mul_start` is high for the cycle after N. WAIT follows at N+1.
- `op_a` and `op_b` are stable from START until leaving WAIT.
- Timeout counter:
  - Reset to 0 on entering WAIT; increments each WAIT cycle.
  - Timeout is declared when it reaches `TIMEOUT_CYC`−1 without `mul_done`.
  - Total WAIT residency on timeout is `TIMEOUT_CYC` cycles.
- `mul_done` seen at edge N in WAIT: `result` is captured and SHOW is entered at N. `disp_value` shows the product one cycle later.
- Reset asserted mid-operation returns all outputs to their reset values immediately (async). No `mul_start` is issued after reset release until a new ENTER/ENTER sequence.

## Structure
- `calc_pkg`: state enum `calc_state_t`, key constants `KEY_ENTER` = 4'hA and `KEY_CLEAR` = 4'hB, `disp_sel` encodings, error display constant 16'hFFFF.
- Sub-module `dec_acc8`: one 8-bit decimal accumulator with digit counter. It has `load_digit`, `clear`, `acc`, and `accepted` ports, and is instantiated twice (A, B).
- Everything else lives in `calc_seq_ctrl`.

## Test plan
- Keys 1, 2, ENTER, 3, 4, ENTER; `mul_done` 3 cycles after `mul_start` with `mul_result` = 408. Expect:
  - `op_a` = 12, `op_b` = 34.
  - Exactly one `mul_start` pulse.
  - `busy` high for 4 cycles.
  - `disp_value` = 408, `disp_sel` = 2.
- Keys 2, 5, 6 into A. Expect A = 25 (256 rejected). Keys 0, 0, 7, 9 into B give B = 7 (fourth digit dropped).
- Enter operands, then withhold `mul_done`. After exactly `TIMEOUT_CYC` WAIT cycles expect:
  - `err` = 1, `disp_value` = 16'hFFFF, `disp_sel` = 3.
  - Then digit 5 gives ENT_A, A = 5, `err` = 0.
- CLEAR in WAIT at the same cycle as `mul_done` with `mul_result` = 99. Expect ENT_A, A = B = 0, `result` = 0, and 99 never displayed.
- Assert `rst` asynchronously in START (mid-clock). Expect `mul_start` to drop immediately and all outputs to return to their reset values. Stray `mul_done` after release has no effect.
- Key codes 4'hC–4'hF in ENT_A, and digits/ENTER during WAIT. Expect no state or operand change.
